// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern checker.
//   LFSR_W        word width of the generator sequence
//   SEED_DEFAULT  first word the generator emits after its own reset
//   lfsr_next     one step of the generator sequence (period 256, includes 8'h00)
//   popcount8     number of set bits in a word, used for bit-error accounting
//   state_t       checker FSM encoding, also exported on o_state
package lfsr_pkg;

  localparam int          LFSR_W       = 8;
  localparam logic [7:0]  SEED_DEFAULT = 8'h01;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Galois-style step with taps at bits 2,3,4. The (s[6:0]==0) term splices
  // 8'h00 into the cycle between 8'h80 and 8'h1D, giving a full 256 period.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic       fb;
    logic [7:0] n;
    fb   = s[7] ^ (s[6:0] == 7'd0);
    n[0] = fb;
    n[1] = s[0];
    n[2] = s[1] ^ fb;
    n[3] = s[2] ^ fb;
    n[4] = s[3] ^ fb;
    n[5] = s[4];
    n[6] = s[5];
    n[7] = s[6];
    return n;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, i_rst   clock, asynchronous active-high reset (count -> 0)
//   i_clear      synchronous clear; takes priority over an increment
//   i_inc        add i_amt this cycle
//   i_amt        increment amount (AMT_W bits)
//   o_cnt        current count, sticks at all-ones
module lfsr_sat_counter #(
  parameter int CNT_W = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic [AMT_W-1:0] i_amt,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int SUM_W = (CNT_W > AMT_W) ? CNT_W + 1 : AMT_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;

  // Sum is carried one bit wider than either operand so any carry out of the
  // CNT_W field is visible and can be turned into saturation.
  assign w_sum = SUM_W'(r_cnt) + SUM_W'(i_amt);
  assign w_ovf = |(w_sum >> CNT_W);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)        r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_inc)   r_cnt <= w_ovf ? '1 : w_sum[CNT_W-1:0];
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR pattern generator. Self-synchronises
// by reseeding its predictor from received words (no seed exchange), then
// flywheels once locked and counts mismatching words.
//   clk, i_rst      clock, asynchronous active-high reset
//   i_valid/i_data  received generator word
//   i_clear         synchronous clear of the error counters (lock untouched)
//   o_locked        high while the FSM is LOCKED
//   o_err           high the cycle after a mismatching word seen while LOCKED
//   o_err_cnt       saturating count of mismatching words while LOCKED
//   o_state         FSM state (lfsr_pkg::state_t encoding)
//   o_bit_err_cnt   saturating count of mismatching bits while LOCKED; present
//                   only when LFSR_CHECKER_BIT_CNT_EN is defined
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int UNLOCK_ERRS  = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [LFSR_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_locked,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [1:0]        o_state
`ifdef LFSR_CHECKER_BIT_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_bit_err_cnt
`endif
);

  localparam logic [3:0] LM = 4'(LOCK_MATCHES);
  localparam logic [3:0] UE = 4'(UNLOCK_ERRS);

  state_t            r_state;
  logic [LFSR_W-1:0] r_pred;
  logic [3:0]        r_match_cnt;
  logic [3:0]        r_miss_cnt;
  logic              r_locked;
  logic              r_err;

  logic              w_hit;
  logic              w_cnt_err;
  logic [LFSR_W-1:0] w_pred_nxt;
  logic [LFSR_W-1:0] w_seed_nxt;

  assign w_hit      = (i_data == r_pred);
  assign w_pred_nxt = lfsr_next(r_pred);
  assign w_seed_nxt = lfsr_next(i_data);
  // Only mismatches seen while LOCKED are errors; HUNT/SYNC misses are just
  // part of acquiring the sequence.
  assign w_cnt_err  = i_valid && (r_state == ST_LOCKED) && !w_hit;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_HUNT;
      r_pred      <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        unique case (r_state)
          ST_HUNT: begin
            r_pred      <= w_seed_nxt;
            r_match_cnt <= '0;
            r_state     <= ST_SYNC;
          end
          ST_SYNC: begin
            if (w_hit) begin
              r_pred <= w_pred_nxt;
              if (r_match_cnt + 4'd1 == LM) begin
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
                r_locked    <= 1'b1;
                r_state     <= ST_LOCKED;
              end else begin
                r_match_cnt <= r_match_cnt + 4'd1;
              end
            end else begin
              // Assume the received word is good and restart from it.
              r_pred      <= w_seed_nxt;
              r_match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Flywheel: a corrupted word must not steer the predictor.
            r_pred <= w_pred_nxt;
            if (w_hit) begin
              r_miss_cnt <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_miss_cnt + 4'd1 == UE) begin
                r_miss_cnt <= '0;
                r_locked   <= 1'b0;
                r_state    <= ST_HUNT;
              end else begin
                r_miss_cnt <= r_miss_cnt + 4'd1;
              end
            end
          end
          default: begin
            r_locked <= 1'b0;
            r_state  <= ST_HUNT;
          end
        endcase
      end
    end
  end

  lfsr_sat_counter #(.CNT_W(CNT_W), .AMT_W(4)) u_err_cnt (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_inc   (w_cnt_err),
    .i_amt   (4'd1),
    .o_cnt   (o_err_cnt)
  );

`ifdef LFSR_CHECKER_BIT_CNT_EN
  logic [3:0] w_bit_amt;
  assign w_bit_amt = popcount8(i_data ^ r_pred);

  lfsr_sat_counter #(.CNT_W(CNT_W), .AMT_W(4)) u_bit_err_cnt (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_inc   (w_cnt_err),
    .i_amt   (w_bit_amt),
    .o_cnt   (o_bit_err_cnt)
  );
`endif

  assign o_locked = r_locked;
  assign o_err    = r_err;
  assign o_state  = r_state;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Downstream consumer of the 8-bit LFSR pattern generator; receives its words, self-synchronises to the sequence and counts mismatching words.
- Used in link/BIST loopback to qualify a data path driven by the generator.
- Locks with no seed exchange: reseeds its local predictor from received data, then flywheels.

Parameters:
LOCK_MATCHES, 4, consecutive matching words required in SYNC before asserting lock (1..15)
UNLOCK_ERRS, 3, consecutive mismatching words in LOCKED before dropping lock (1..15)
CNT_W, 16, width of saturating error counters

Ports:
clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  i_data carries a new generator word this cycle
i_data  in  8  received generator word
i_clear  in  1  synchronous clear of error counters (lock state untouched)
o_locked  out  1  checker synchronised to sequence
o_err  out  1  one-cycle pulse: current valid word mismatched while LOCKED
o_err_cnt  out  CNT_W  mismatching words counted while LOCKED, saturating
o_state  out  2  FSM state for debug (encoding per package)

Behaviour:
- Reset i_rst, asynchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: FSM=HUNT, pred=8'h00, match/miss counters=0, o_locked=0, o_err=0, o_err_cnt=0.
- next(s): fb = s[7] ^ (s[6:0]==0); n[0]=fb, n[1]=s[0], n[2]=s[1]^fb, n[3]=s[2]^fb, n[4]=s[3]^fb, n[5]=s[4], n[6]=s[5], n[7]=s[6]. Period 256, includes 8'h00. Example: 01,02,04,08,10,20,40,80,00,1D,3A.
- Nothing changes when i_valid=0 (except i_clear); state advances only on valid words.
- HUNT: on valid word: pred<=next(i_data), match_cnt<=0, go SYNC.
- SYNC: on valid word: if i_data==pred: pred<=next(pred), match_cnt+1; if new count==LOCK_MATCHES go LOCKED. On mismatch: reseed pred<=next(i_data), match_cnt<=0, stay SYNC.
- LOCKED: on every valid word pred<=next(pred) (flywheel, never reseed). Match: miss_cnt<=0. Mismatch: o_err=1 next cycle, o_err_cnt+1 (saturate at all-ones), miss_cnt+1; if new miss_cnt==UNLOCK_ERRS go HUNT, miss_cnt<=0.
- o_locked registered: high exactly while FSM==LOCKED; rises the cycle after the LOCK_MATCHES-th matching word is sampled.
- No errors counted in HUNT/SYNC.
- i_clear same cycle as a counted error: clear wins, counter=0, o_err still pulses.
- Reset mid-operation: immediate return to HUNT, all counters zero.

Optional Feature:
- Macro LFSR_CHECKER_BIT_CNT_EN.
- Defined: extra port o_bit_err_cnt (CNT_W, out); on each LOCKED mismatch adds popcount(i_data ^ pred) (0..8), saturating; cleared by i_clear/reset like o_err_cnt.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package lfsr_pkg: LFSR_W=8, SEED_DEFAULT=8'h01, next-state function lfsr_next, FSM state encoding (HUNT=0, SYNC=1, LOCKED=2).
- Sub-module lfsr_sat_counter (CNT_W, clear, inc, inc amount), instanced for o_err_cnt and, with feature enabled, o_bit_err_cnt.

Test Plan:
- Clean lock: valid words 01,02,04,08,10 -> SYNC after 01, o_locked=1 cycle after 10, o_err_cnt=0.
- Zero-state wrap: locked stream continues 20,40,80,00,1D,3A -> no o_err; 00->1D transition accepted.
- Single error: locked, expected 04, send 05, then correct stream -> one o_err pulse, o_err_cnt=1, stays locked; feature on: o_bit_err_cnt=1.
- Loss of lock: locked, send 3 words of 8'hFF -> o_err_cnt=3, o_locked=0 after third; resend 01,02,04,08,10 -> relock.
- SYNC reseed + gaps: send 01,55,AA then 55's successors with i_valid gaps between -> reseed on 55, lock after 4 matches, idle cycles change nothing.
- Saturation/clear: CNT_W=4, force 20 errors with UNLOCK_ERRS=15 interleaved with matches -> o_err_cnt holds 4'hF; i_clear coincident with error -> 0; i_rst mid-SYNC -> HUNT, outputs zero.
